ecc_decode_pipe: RTL and testbench
==================================

# ecc_decode_pipe

Pipelined SECDED decoder for the (39,32) Hamming codewords that the FPGA RAM model stores. It sits directly downstream of the RAM read port and consumes the codewords the write-side encoder produced. It corrects single-bit errors, flags double or uncorrectable errors, passes a sideband tag through, and keeps saturating error statistics. Valid/ready on both sides, fixed 2-cycle latency.

## Interface
- P_DATAWIDTH, 32: decoded data width.
- P_CODEWIDTH, 39: codeword width (38 Hamming bits plus overall parity).
- P_TAGWIDTH, 16: sideband tag width (typically the RAM address).
- P_CNTWIDTH, 16: error counter width.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  codeword valid.
- in_ready  out  1  decoder can accept.
- code_in  in  P_CODEWIDTH  codeword.
- tag_in  in  P_TAGWIDTH  sideband tag, travels with the codeword.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- data_out  out  P_DATAWIDTH  corrected data.
- tag_out  out  P_TAGWIDTH  tag of this result.
- err_corr  out  1  single error corrected in this result.
- err_uncorr  out  1  double/uncorrectable error; data_out is the raw, uncorrected data bits.
- syndrome_out  out  6  Hamming syndrome of this result.
- corr_cnt  out  P_CNTWIDTH  saturating count of corrected words.
- uncorr_cnt  out  P_CNTWIDTH  saturating count of uncorrectable words.
- first_err_tag  out  P_TAGWIDTH  tag of the first uncorrectable word since reset/clear.
- first_err_vld  out  1  first_err_tag holds a value.
- stat_clr  in  1  clear counters and first-error log.

## Operation
- Codeword layout: positions 1..38 map to code bits [0..37]. Parity sits at positions 1, 2, 4, 8, 16, 32. Data bits 0..31 fill the remaining positions in ascending order. Bit 38 is even parity over bits [0..37].
- Syndrome: bit k (k=0..5) = XOR of code bits at positions with bit k set. p = XOR of all 39 bits.
- s=0, p=0: clean.
- p=1, s=0: error in bit 38. err_corr=1, data unchanged.
- p=1, 1≤s≤38: flip the bit at position s, then extract data. err_corr=1.
- p=1, s≥39: err_uncorr=1.
- s≠0, p=0: err_uncorr=1.
- err_corr and err_uncorr are never both 1.
- Stage 1 registers code, tag, syndrome and p. Stage 2 registers corrected data, flags, syndrome and tag.
- Stall: each stage advances when its output slot is empty or is being taken downstream. in_ready = !s1_full || s1_advance. Full throughput is 1 word/cycle with out_ready=1.
- Counters and log update on the output handshake (out_valid && out_ready), once per word.
  - corr_cnt increments on err_corr; uncorr_cnt increments on err_uncorr. Both saturate at all-ones.
  - first_err_tag loads tag_out on an uncorrectable handshake while first_err_vld=0, and first_err_vld goes to 1.
- stat_clr has priority over a same-cycle increment or log load: that event is discarded.

## Timing
- Latency: a word accepted in cycle n reaches out_valid in cycle n+2 when there is no backpressure.
- While out_valid=1 and out_ready=0: every output holds stable, and no input word is lost or duplicated.
- Reset values, applied at the edge with rst_n=0:
  - Stage-valid flags, out_valid, err_corr, err_uncorr, first_err_vld: 0.
  - corr_cnt, uncorr_cnt: 0.
  - data_out, tag_out, syndrome_out, first_err_tag: 0.
  - in_ready is 1 in the first cycle after reset.
- Reset asserted mid-stream drops all in-flight words; no partial outputs.
- in_valid is ignored while rst_n=0.

## Structure
- Shared package ecc_pkg:
  - Width constants (32/39/6).
  - Parity-position list.
  - Function ecc_syndrome(code) returning {p, s}.
  - Function ecc_extract(code) returning data bits.
  - The encoder side reuses the same package.
- One sub-module: ecc_decode_core. Combinational correction from a registered code, syndrome and p to data and flags; instantiated in stage 2.
- The pipeline, handshake and statistics stay in ecc_decode_pipe.

## Test plan
- Clean stream: 0xDEADBEEF encoded, tag 0x0010 → data_out 0xDEADBEEF, no flags, syndrome 0, counters 0.
- Single error: flip code bit 2 (position 3, data bit 0) of 0xDEADBEEF → data_out 0xDEADBEEF, err_corr=1, syndrome 3, corr_cnt=1. Flipping bit 38 instead → err_corr=1, syndrome 0.
- Double error: flip code bits 2 and 4 of 0x12345678, tag 0x00A5.
  - Result: err_uncorr=1, syndrome 6, data_out = raw extracted bits.
  - uncorr_cnt=1, first_err_tag=0x00A5 with first_err_vld=1.
  - A second such word with tag 0x00A6 leaves first_err_tag unchanged.
- Out-of-range syndrome: flip positions 32, 3, 4 → p=1, s=39 → err_uncorr=1 and no bit flipped.
- Backpressure: stream 8 words with out_ready toggling (1,0,0,1,...) → all 8 emerge in order, no duplicates, outputs stable while stalled; with out_ready=1, throughput is 1 word/cycle.
- Saturation and clear:
  - With P_CNTWIDTH=4, send 20 single-error words → corr_cnt=15.
  - stat_clr coincident with a corrected handshake → corr_cnt=0 and first_err_vld=0 next cycle.
  - rst_n low mid-stream → out_valid=0 next cycle.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared (39,32) SECDED definitions used by both the RAM-side encoder and the decoder.
// Position p (1..38) lives in code bit p-1; bit 38 is overall even parity.
package ecc_pkg;

  localparam int ECC_DATA_W = 32;
  localparam int ECC_CODE_W = 39;
  localparam int ECC_SYN_W  = 6;
  localparam int ECC_NPAR   = 6;
  localparam int ECC_PAR_POS [ECC_NPAR] = '{1, 2, 4, 8, 16, 32};

  function automatic logic is_par_pos(input int pos);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < ECC_NPAR; k++) begin
      if (ECC_PAR_POS[k] == pos) hit = 1'b1;
    end
    return hit;
  endfunction

  // Returns {overall parity, 6-bit Hamming syndrome}.
  function automatic logic [ECC_SYN_W:0] ecc_syndrome(input logic [ECC_CODE_W-1:0] code);
    logic [ECC_SYN_W-1:0] s;
    s = '0;
    for (int pos = 1; pos < ECC_CODE_W; pos++) begin
      if (code[6'(pos - 1)]) s = s ^ ECC_SYN_W'(pos);
    end
    return {^code, s};
  endfunction

  function automatic logic [ECC_DATA_W-1:0] ecc_extract(input logic [ECC_CODE_W-1:0] code);
    logic [ECC_DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int pos = 1; pos < ECC_CODE_W; pos++) begin
      if (!is_par_pos(pos)) begin
        d[5'(j)] = code[6'(pos - 1)];
        j++;
      end
    end
    return d;
  endfunction

  function automatic logic [ECC_CODE_W-1:0] ecc_encode(input logic [ECC_DATA_W-1:0] data);
    logic [ECC_CODE_W-1:0] c;
    logic [ECC_SYN_W:0]    ps;
    int j;
    c = '0;
    j = 0;
    for (int pos = 1; pos < ECC_CODE_W; pos++) begin
      if (!is_par_pos(pos)) begin
        c[6'(pos - 1)] = data[5'(j)];
        j++;
      end
    end
    // Each parity position only feeds its own syndrome bit, so the data syndrome is the parity.
    ps = ecc_syndrome(c);
    for (int k = 0; k < ECC_NPAR; k++) begin
      c[6'(ECC_PAR_POS[k] - 1)] = ps[3'(k)];
    end
    c[ECC_CODE_W-1] = ^c[ECC_CODE_W-2:0];
    return c;
  endfunction

endpackage

// File: rtl/ecc_decode_core.sv
// Combinational SECDED correction: flips the bit named by the syndrome and classifies the word.
module ecc_decode_core
  import ecc_pkg::*;
(
  input  logic [ECC_CODE_W-1:0] code_i,
  input  logic [ECC_SYN_W-1:0]  syn_i,
  input  logic                  par_i,
  output logic [ECC_DATA_W-1:0] data_o,
  output logic                  corr_o,
  output logic                  uncorr_o
);

  logic [ECC_CODE_W-1:0] flip;
  logic [ECC_CODE_W-1:0] fixed;
  logic                  in_range;

  assign in_range = (syn_i <= ECC_SYN_W'(ECC_CODE_W - 1));

  for (genvar gi = 0; gi < ECC_CODE_W - 1; gi++) begin : g_flip
    assign flip[gi] = par_i && (syn_i == ECC_SYN_W'(gi + 1));
  end
  // An error in the overall parity bit needs no data fix-up.
  assign flip[ECC_CODE_W-1] = 1'b0;

  assign fixed    = code_i ^ flip;
  assign data_o   = ecc_extract(fixed);
  assign corr_o   = par_i && in_range;
  assign uncorr_o = (par_i && !in_range) || (!par_i && (syn_i != '0));

endmodule

// File: rtl/ecc_decode_pipe.sv
// Two-stage valid/ready SECDED decoder with tag passthrough and saturating error statistics.
module ecc_decode_pipe
  import ecc_pkg::*;
#(
  parameter int P_DATAWIDTH = 32,
  parameter int P_CODEWIDTH = 39,
  parameter int P_TAGWIDTH  = 16,
  parameter int P_CNTWIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [P_CODEWIDTH-1:0] code_in,
  input  logic [P_TAGWIDTH-1:0]  tag_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [P_DATAWIDTH-1:0] data_out,
  output logic [P_TAGWIDTH-1:0]  tag_out,
  output logic                   err_corr,
  output logic                   err_uncorr,
  output logic [5:0]             syndrome_out,
  output logic [P_CNTWIDTH-1:0]  corr_cnt,
  output logic [P_CNTWIDTH-1:0]  uncorr_cnt,
  output logic [P_TAGWIDTH-1:0]  first_err_tag,
  output logic                   first_err_vld,
  input  logic                   stat_clr
);

  localparam logic [P_CNTWIDTH-1:0] CNT_MAX = '1;

  logic                   s1_valid_q, s1_valid_d;
  logic [P_CODEWIDTH-1:0] s1_code_q, s1_code_d;
  logic [P_TAGWIDTH-1:0]  s1_tag_q, s1_tag_d;
  logic [ECC_SYN_W-1:0]   s1_syn_q, s1_syn_d;
  logic                   s1_par_q, s1_par_d;

  logic                   s2_valid_q, s2_valid_d;
  logic [P_DATAWIDTH-1:0] s2_data_q, s2_data_d;
  logic [P_TAGWIDTH-1:0]  s2_tag_q, s2_tag_d;
  logic                   s2_corr_q, s2_corr_d;
  logic                   s2_uncorr_q, s2_uncorr_d;
  logic [ECC_SYN_W-1:0]   s2_syn_q, s2_syn_d;

  logic [P_CNTWIDTH-1:0]  corr_cnt_q, corr_cnt_d;
  logic [P_CNTWIDTH-1:0]  uncorr_cnt_q, uncorr_cnt_d;
  logic [P_TAGWIDTH-1:0]  first_tag_q, first_tag_d;
  logic                   first_vld_q, first_vld_d;

  logic                   s2_free;
  logic                   out_hs;
  logic [ECC_SYN_W:0]     in_ps;
  logic [ECC_DATA_W-1:0]  core_data;
  logic                   core_corr;
  logic                   core_uncorr;

  assign s2_free  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign out_hs   = s2_valid_q && out_ready;
  assign in_ps    = ecc_syndrome(code_in);

  ecc_decode_core u_core (
    .code_i   (s1_code_q),
    .syn_i    (s1_syn_q),
    .par_i    (s1_par_q),
    .data_o   (core_data),
    .corr_o   (core_corr),
    .uncorr_o (core_uncorr)
  );

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_code_d    = s1_code_q;
    s1_tag_d     = s1_tag_q;
    s1_syn_d     = s1_syn_q;
    s1_par_d     = s1_par_q;
    s2_valid_d   = s2_valid_q;
    s2_data_d    = s2_data_q;
    s2_tag_d     = s2_tag_q;
    s2_corr_d    = s2_corr_q;
    s2_uncorr_d  = s2_uncorr_q;
    s2_syn_d     = s2_syn_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    first_tag_d  = first_tag_q;
    first_vld_d  = first_vld_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_code_d = code_in;
        s1_tag_d  = tag_in;
        s1_syn_d  = in_ps[ECC_SYN_W-1:0];
        s1_par_d  = in_ps[ECC_SYN_W];
      end
    end

    // Payload registers only move when a word actually advances, so stalled outputs hold.
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d   = core_data;
        s2_tag_d    = s1_tag_q;
        s2_corr_d   = core_corr;
        s2_uncorr_d = core_uncorr;
        s2_syn_d    = s1_syn_q;
      end
    end

    if (stat_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
      first_tag_d  = '0;
      first_vld_d  = 1'b0;
    end else if (out_hs) begin
      if (s2_corr_q && (corr_cnt_q != CNT_MAX)) corr_cnt_d = corr_cnt_q + 1'b1;
      if (s2_uncorr_q) begin
        if (uncorr_cnt_q != CNT_MAX) uncorr_cnt_d = uncorr_cnt_q + 1'b1;
        if (!first_vld_q) begin
          first_tag_d = s2_tag_q;
          first_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_tag_q     <= '0;
      s1_syn_q     <= '0;
      s1_par_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_tag_q     <= '0;
      s2_corr_q    <= 1'b0;
      s2_uncorr_q  <= 1'b0;
      s2_syn_q     <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
      first_tag_q  <= '0;
      first_vld_q  <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_code_q    <= s1_code_d;
      s1_tag_q     <= s1_tag_d;
      s1_syn_q     <= s1_syn_d;
      s1_par_q     <= s1_par_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_tag_q     <= s2_tag_d;
      s2_corr_q    <= s2_corr_d;
      s2_uncorr_q  <= s2_uncorr_d;
      s2_syn_q     <= s2_syn_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      first_tag_q  <= first_tag_d;
      first_vld_q  <= first_vld_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign data_out      = s2_data_q;
  assign tag_out       = s2_tag_q;
  assign err_corr      = s2_corr_q;
  assign err_uncorr    = s2_uncorr_q;
  assign syndrome_out  = s2_syn_q;
  assign corr_cnt      = corr_cnt_q;
  assign uncorr_cnt    = uncorr_cnt_q;
  assign first_err_tag = first_tag_q;
  assign first_err_vld = first_vld_q;

endmodule

// File: tb/tb_ecc_decode_pipe.sv
// Scoreboard bench for ecc_decode_pipe: directed codewords in, monitor checks each output handshake.
module tb_ecc_decode_pipe;

  localparam int DW = 32;
  localparam int CW = 39;
  localparam int TW = 16;
  localparam int NW = 4;
  localparam int CMAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] code_in;
  logic [TW-1:0] tag_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_out;
  logic [TW-1:0] tag_out;
  logic          err_corr;
  logic          err_uncorr;
  logic [5:0]    syndrome_out;
  logic [NW-1:0] corr_cnt;
  logic [NW-1:0] uncorr_cnt;
  logic [TW-1:0] first_err_tag;
  logic          first_err_vld;
  logic          stat_clr;

  always #5 clk = ~clk;

  ecc_decode_pipe #(
    .P_DATAWIDTH (DW),
    .P_CODEWIDTH (CW),
    .P_TAGWIDTH  (TW),
    .P_CNTWIDTH  (NW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .code_in       (code_in),
    .tag_in        (tag_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .data_out      (data_out),
    .tag_out       (tag_out),
    .err_corr      (err_corr),
    .err_uncorr    (err_uncorr),
    .syndrome_out  (syndrome_out),
    .corr_cnt      (corr_cnt),
    .uncorr_cnt    (uncorr_cnt),
    .first_err_tag (first_err_tag),
    .first_err_vld (first_err_vld),
    .stat_clr      (stat_clr)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          corr;
    logic          uncorr;
    logic [5:0]    syn;
  } exp_t;

  exp_t          exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            last_wait = 0;
  int            m_corr = 0;
  int            m_uncorr = 0;
  logic [TW-1:0] m_ftag = '0;
  logic          m_fvld = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Independent (39,32) encoder: data into non-power-of-two positions, then parity.
  function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    logic          pb;
    int            j;
    c = '0;
    j = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[6'(pos - 1)] = d[5'(j)];
        j++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      pb = 1'b0;
      for (int pos = 1; pos <= 38; pos++) begin
        if (((pos >> k) & 1) == 1) pb = pb ^ c[6'(pos - 1)];
      end
      c[6'((1 << k) - 1)] = pb;
    end
    c[38] = ^c[37:0];
    return c;
  endfunction

  task automatic send(input logic [CW-1:0] c, input logic [TW-1:0] t, input logic [DW-1:0] d,
                      input logic ec, input logic eu, input logic [5:0] s);
    exp_t e;
    int   w;
    w        = 0;
    code_in  = c;
    tag_in   = t;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    last_wait = w;
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: tag 0x%0h not accepted after %0d cycles, expected acceptance", t, w);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end else begin
      e.data   = d;
      e.tag    = t;
      e.corr   = ec;
      e.uncorr = eu;
      e.syn    = s;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d words outstanding, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each presented output to the queue head, checks stall stability, tracks stats.
  initial begin
    exp_t          e;
    logic          held;
    logic          popped;
    logic [55:0]   snap;
    held = 1'b0;
    e    = '0;
    snap = '0;
    forever begin
      @(negedge clk);
      popped = 1'b0;
      if (!rst_n) begin
        exp_q.delete();
        m_corr   = 0;
        m_uncorr = 0;
        m_ftag   = '0;
        m_fvld   = 1'b0;
        held     = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", 64'(out_valid), 64'(1));
          chk("hold_outputs", 64'({data_out, tag_out, syndrome_out, err_corr, err_uncorr}), 64'(snap));
        end
        held = 1'b0;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: tag 0x%0h data 0x%0h, expected no output", tag_out, data_out);
          end else begin
            e = exp_q[0];
            chk("data_out", 64'(data_out), 64'(e.data));
            chk("tag_out", 64'(tag_out), 64'(e.tag));
            chk("err_corr", 64'(err_corr), 64'(e.corr));
            chk("err_uncorr", 64'(err_uncorr), 64'(e.uncorr));
            chk("syndrome_out", 64'(syndrome_out), 64'(e.syn));
            if (out_ready) begin
              chk("corr_cnt", 64'(corr_cnt), 64'(m_corr));
              chk("uncorr_cnt", 64'(uncorr_cnt), 64'(m_uncorr));
              chk("first_err_vld", 64'(first_err_vld), 64'(m_fvld));
              chk("first_err_tag", 64'(first_err_tag), 64'(m_ftag));
              void'(exp_q.pop_front());
              popped = 1'b1;
            end else begin
              held = 1'b1;
              snap = {data_out, tag_out, syndrome_out, err_corr, err_uncorr};
            end
          end
        end
        if (stat_clr) begin
          m_corr   = 0;
          m_uncorr = 0;
          m_ftag   = '0;
          m_fvld   = 1'b0;
        end else if (popped) begin
          if (e.corr && m_corr < CMAX) m_corr++;
          if (e.uncorr) begin
            if (m_uncorr < CMAX) m_uncorr++;
            if (!m_fvld) begin
              m_fvld = 1'b1;
              m_ftag = e.tag;
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] vals [8];
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    int            k;
    vals = '{32'h00000000, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h5A5A5A5A,
             32'h00000001, 32'h80000000, 32'h12345678, 32'hCAFEF00D};

    // Reset with in_valid high: must be ignored.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    code_in   = enc(32'h0BADF00D);
    tag_in    = 16'hFFFF;
    out_ready = 1'b1;
    stat_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_err_flags", 64'({err_corr, err_uncorr}), 64'(0));
    chk("rst_data_tag_syn", 64'({data_out, tag_out, syndrome_out}), 64'(0));
    chk("rst_counters", 64'({corr_cnt, uncorr_cnt}), 64'(0));
    chk("rst_first_err", 64'({first_err_vld, first_err_tag}), 64'(0));
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("in_ready_after_reset", 64'(in_ready), 64'(1));
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("no_output_after_reset", 64'(out_valid), 64'(0));
    end

    // Clean word, then a back-to-back clean stream.
    send(enc(32'hDEADBEEF), 16'h0010, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0);
    drain();
    chk("clean_corr_cnt", 64'(corr_cnt), 64'(0));
    for (int i = 0; i < 8; i++) begin
      send(enc(vals[i]), 16'h0020 + 16'(i), vals[i], 1'b0, 1'b0, 6'd0);
      chk("throughput_accept_wait", 64'(last_wait), 64'(0));
    end
    drain();

    // Single errors: data bit 0 (position 3), then overall parity bit.
    c = enc(32'hDEADBEEF);
    c[2] = ~c[2];
    send(c, 16'h0011, 32'hDEADBEEF, 1'b1, 1'b0, 6'd3);
    drain();
    chk("single_corr_cnt", 64'(corr_cnt), 64'(1));
    c = enc(32'hDEADBEEF);
    c[38] = ~c[38];
    send(c, 16'h0012, 32'hDEADBEEF, 1'b1, 1'b0, 6'd0);
    drain();
    chk("p38_corr_cnt", 64'(corr_cnt), 64'(2));

    // Double errors at positions 3 and 5: raw data with bits 0,1 flipped.
    c = enc(32'h12345678);
    c[2] = ~c[2];
    c[4] = ~c[4];
    send(c, 16'h00A5, 32'h1234567B, 1'b0, 1'b1, 6'd6);
    drain();
    chk("double_uncorr_cnt", 64'(uncorr_cnt), 64'(1));
    chk("double_first_tag", 64'({first_err_vld, first_err_tag}), 64'({1'b1, 16'h00A5}));
    send(c, 16'h00A6, 32'h1234567B, 1'b0, 1'b1, 6'd6);
    drain();
    chk("double2_uncorr_cnt", 64'(uncorr_cnt), 64'(2));
    chk("double2_first_tag", 64'(first_err_tag), 64'(16'h00A5));

    // Positions 32, 3, 4: p=1, s=39, nothing corrected.
    c = enc(32'hDEADBEEF);
    c[31] = ~c[31];
    c[2]  = ~c[2];
    c[3]  = ~c[3];
    send(c, 16'h0030, 32'hDEADBEEE, 1'b0, 1'b1, 6'd39);
    drain();
    chk("oor_uncorr_cnt", 64'(uncorr_cnt), 64'(3));

    // Backpressure with out_ready pattern 1,0,0,1.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(enc(vals[i] ^ 32'h5A5A0000), 16'h0100 + 16'(i), vals[i] ^ 32'h5A5A0000,
               1'b0, 1'b0, 6'd0);
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          out_ready = ((j % 4) == 0) || ((j % 4) == 3);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // stat_clr on the same cycle a corrected word is taken.
    c = enc(32'h0F0F0F0F);
    c[9] = ~c[9];
    send(c, 16'h0040, 32'h0F0F0F0F, 1'b1, 1'b0, 6'd10);
    @(posedge clk);
    #1;
    chk("clr_coincident_valid", 64'(out_valid), 64'(1));
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    chk("clr_corr_cnt", 64'(corr_cnt), 64'(0));
    chk("clr_uncorr_cnt", 64'(uncorr_cnt), 64'(0));
    chk("clr_first_vld", 64'(first_err_vld), 64'(0));
    drain();

    // Saturation: 20 corrected words into a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      d = 32'hC0DE0000 + 32'(i);
      k = (2 * i) % 38;
      c = enc(d);
      c[6'(k)] = ~c[6'(k)];
      send(c, 16'h0200 + 16'(i), d, 1'b1, 1'b0, 6'(k + 1));
    end
    drain();
    chk("sat_corr_cnt", 64'(corr_cnt), 64'(15));

    // Reset mid-stream drops in-flight words.
    send(enc(32'h11111111), 16'h0300, 32'h11111111, 1'b0, 1'b0, 6'd0);
    send(enc(32'h22222222), 16'h0301, 32'h22222222, 1'b0, 1'b0, 6'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_corr_cnt", 64'(corr_cnt), 64'(0));
    rst_n = 1'b1;
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("midrst_no_partial", 64'(out_valid), 64'(0));
    end
    send(enc(32'h33333333), 16'h0302, 32'h33333333, 1'b0, 1'b0, 6'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
